// File: rtl/pwm_duty_meas.sv
// Recovers the duty value of an asynchronous PWM waveform, one result per full period.
// Flags periods that are not 2**W clocks long, and detects a flat input by timeout.
module pwm_duty_meas #(
  parameter int unsigned W = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         PWM_in,
  output logic [W-1:0] duty,
  output logic         vld,
  output logic         period_err,
  output logic         stuck
);

  localparam int unsigned CW = W + 1;
  localparam int unsigned TW = W + 2;
  localparam logic [CW-1:0] PERIOD  = CW'(1) << W;
  localparam logic [TW-1:0] TIMEOUT = TW'(1) << (W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MEAS  = 2'd1,
    STUCK = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [CW-1:0] per_cnt_q, per_cnt_d;
  logic [CW-1:0] hi_cnt_q, hi_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [W-1:0]  duty_q, duty_d;
  logic          vld_q, vld_d;
  logic          perr_q, perr_d;
  logic          stuck_q, stuck_d;
  logic          rise_c;
  logic          to_hit_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      per_cnt_q <= '0;
      hi_cnt_q  <= '0;
      to_cnt_q  <= '0;
      duty_q    <= '0;
      vld_q     <= 1'b0;
      perr_q    <= 1'b0;
      stuck_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
      per_cnt_q <= per_cnt_d;
      hi_cnt_q  <= hi_cnt_d;
      to_cnt_q  <= to_cnt_d;
      duty_q    <= duty_d;
      vld_q     <= vld_d;
      perr_q    <= perr_d;
      stuck_q   <= stuck_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    per_cnt_d = per_cnt_q;
    hi_cnt_d  = hi_cnt_q;
    to_cnt_d  = to_cnt_q;
    duty_d    = duty_q;
    stuck_d   = stuck_q;
    vld_d     = 1'b0;
    perr_d    = 1'b0;
    s1_d      = PWM_in;
    s2_d      = s1_q;
    s3_d      = s2_q;

    rise_c   = s2_q & ~s3_q;
    // A rise coinciding with the timeout wins: to_hit_c excludes it.
    to_hit_c = ~rise_c && (to_cnt_q == TIMEOUT - TW'(1));

    // Saturating counters; the rise sample itself counts as high.
    if (rise_c) begin
      per_cnt_d = CW'(1);
      hi_cnt_d  = CW'(1);
      to_cnt_d  = '0;
    end else begin
      if (per_cnt_q != '1) per_cnt_d = per_cnt_q + CW'(1);
      if (s2_q && (hi_cnt_q != '1)) hi_cnt_d = hi_cnt_q + CW'(1);
      if (to_cnt_q != TIMEOUT) to_cnt_d = to_cnt_q + TW'(1);
    end

    case (state_q)
      IDLE: begin
        if (rise_c) begin
          state_d = MEAS;
        end else if (to_hit_c) begin
          state_d = STUCK;
          stuck_d = 1'b1;
          vld_d   = 1'b1;
          duty_d  = s2_q ? '1 : '0;
        end
      end
      MEAS: begin
        if (rise_c) begin
          if (per_cnt_q == PERIOD) begin
            duty_d  = hi_cnt_q[W] ? '1 : hi_cnt_q[W-1:0];
            vld_d   = 1'b1;
            stuck_d = 1'b0;
          end else begin
            perr_d = 1'b1;
          end
        end else if (to_hit_c) begin
          state_d = STUCK;
          stuck_d = 1'b1;
          vld_d   = 1'b1;
          duty_d  = s2_q ? '1 : '0;
        end
      end
      STUCK: begin
        if (rise_c) state_d = MEAS;
      end
      default: state_d = IDLE;
    endcase
  end

  assign duty       = duty_q;
  assign vld        = vld_q;
  assign period_err = perr_q;
  assign stuck      = stuck_q;

endmodule

// File: tb/tb_pwm_duty_meas.sv
// Directed bench for pwm_duty_meas: good periods, stuck low/high, bad periods, mid-frame reset.
module tb_pwm_duty_meas;

  localparam int unsigned W = 11;

  logic         clk;
  logic         rst_n;
  logic         PWM_in;
  logic [W-1:0] duty;
  logic         vld;
  logic         period_err;
  logic         stuck;

  int errors = 0;
  int checks = 0;

  int cyc      = 0;
  int vld_cnt  = 0;
  int perr_cnt = 0;
  int both_cnt = 0;
  int prev_vld = -1;
  int last_gap = 0;
  int v0;
  int p0;

  pwm_duty_meas #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .PWM_in     (PWM_in),
    .duty       (duty),
    .vld        (vld),
    .period_err (period_err),
    .stuck      (stuck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor sampled on the falling edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (vld) begin
      vld_cnt <= vld_cnt + 1;
      if (prev_vld >= 0) last_gap <= cyc - prev_vld;
      prev_vld <= cyc;
    end
    if (period_err) perr_cnt <= perr_cnt + 1;
    if (vld && period_err) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_period(input int hi, input int per);
    for (int i = 0; i < per; i++) begin
      PWM_in = (i < hi);
      @(negedge clk);
    end
  endtask

  task automatic hold(input logic val, input int n);
    PWM_in = val;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n  = 1'b0;
    PWM_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_duty", 32'(duty), 32'h0);
    chk("rst_vld", 32'(vld), 32'h0);
    chk("rst_perr", 32'(period_err), 32'h0);
    chk("rst_stuck", 32'(stuck), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Four nominal periods at 0x400: rises 2..4 each produce a result.
    repeat (4) run_period(32'h400, 2048);
    chk("nom_vld_cnt", 32'(vld_cnt), 32'd3);
    chk("nom_duty", 32'(duty), 32'h400);
    chk("nom_gap", 32'(last_gap), 32'd2048);
    chk("nom_perr", 32'(perr_cnt), 32'd0);
    chk("nom_stuck", 32'(stuck), 32'h0);

    // Extreme duties 0x001 then 0x7FF.
    p0 = perr_cnt;
    repeat (2) run_period(32'h001, 2048);
    chk("duty_min", 32'(duty), 32'h001);
    repeat (2) run_period(32'h7FF, 2048);
    chk("duty_max", 32'(duty), 32'h7FF);
    chk("ext_perr", 32'(perr_cnt - p0), 32'd0);

    // Stuck low.
    v0 = vld_cnt;
    p0 = perr_cnt;
    hold(1'b0, 5000);
    chk("sl_stuck", 32'(stuck), 32'h1);
    chk("sl_duty", 32'(duty), 32'h000);
    chk("sl_vld", 32'(vld_cnt - v0), 32'd1);
    chk("sl_perr", 32'(perr_cnt - p0), 32'd0);

    // Recovery: first rise only restarts measurement; second rise clears stuck.
    v0 = vld_cnt;
    run_period(32'h200, 2048);
    chk("slr_stuck_hold", 32'(stuck), 32'h1);
    run_period(32'h200, 2048);
    chk("slr_stuck", 32'(stuck), 32'h0);
    chk("slr_duty", 32'(duty), 32'h200);
    chk("slr_vld", 32'(vld_cnt - v0), 32'd1);

    // Stuck high: the rise at hold start closes a good 0x200 period, then timeout.
    v0 = vld_cnt;
    hold(1'b1, 5000);
    chk("sh_stuck", 32'(stuck), 32'h1);
    chk("sh_duty", 32'(duty), 32'h7FF);
    chk("sh_vld", 32'(vld_cnt - v0), 32'd2);

    // Recovery from high: no rise at the first period start.
    v0 = vld_cnt;
    repeat (2) run_period(32'h300, 2048);
    chk("shr_stuck_hold", 32'(stuck), 32'h1);
    chk("shr_duty_hold", 32'(duty), 32'h7FF);
    run_period(32'h300, 2048);
    chk("shr_stuck", 32'(stuck), 32'h0);
    chk("shr_duty", 32'(duty), 32'h300);
    chk("shr_vld", 32'(vld_cnt - v0), 32'd1);

    // 2000-clock periods: first rise still closes the last good period.
    run_period(1000, 2000);
    v0 = vld_cnt;
    p0 = perr_cnt;
    repeat (3) run_period(1000, 2000);
    chk("pe_perr", 32'(perr_cnt - p0), 32'd3);
    chk("pe_vld", 32'(vld_cnt - v0), 32'd0);
    chk("pe_duty", 32'(duty), 32'h300);
    chk("pe_both", 32'(both_cnt), 32'd0);

    // Reset pulsed mid-high-phase.
    run_period(32'h400, 2048);
    PWM_in = 1'b1;
    repeat (500) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("mr_duty", 32'(duty), 32'h0);
    chk("mr_vld", 32'(vld), 32'h0);
    chk("mr_perr", 32'(period_err), 32'h0);
    chk("mr_stuck", 32'(stuck), 32'h0);
    rst_n = 1'b1;
    v0 = vld_cnt;
    hold(1'b1, 32'h400 - 503);
    hold(1'b0, 1024);
    run_period(32'h400, 2048);
    chk("mr_vld_none", 32'(vld_cnt - v0), 32'd0);
    chk("mr_duty_zero", 32'(duty), 32'h0);
    run_period(32'h400, 2048);
    chk("mr_vld_first", 32'(vld_cnt - v0), 32'd1);
    chk("mr_duty_first", 32'(duty), 32'h400);
    chk("end_both", 32'(both_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
